dmem_responder: RTL and testbench

- Data-memory responder: the memory side of the CPU memory-stage interface.
- Serves single-word read/write requests over a valid/ready request channel.
- Returns each result over a valid/ready response channel after a configurable number of wait states.
- Flags out-of-range addresses as an error instead of touching storage.
- Sits between the SEQ/PIPE memory stage (initiator) and the data storage.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Types and defaults shared by the data-memory responder and its storage array.
package dmem_pkg;

    localparam int WORD_W              = 64;
    localparam int DEPTH_DEFAULT       = 1024;
    localparam int INIT_WORDS_DEFAULT  = 21;
    localparam int WAIT_CYCLES_DEFAULT = 1;
    localparam int CNT_W               = 4;    // wait-state counter, covers 0..15

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM backing the responder. Words below INIT_WORDS
// power up holding their own index; everything else powers up as zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int   DEPTH      = DEPTH_DEFAULT,
    parameter int   INIT_WORDS = INIT_WORDS_DEFAULT,
    localparam int  AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    typedef logic [WORD_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = (i < INIT_WORDS) ? WORD_W'(i) : '0;
        end
        return img;
    endfunction

    // NOTE: the storage array has no reset; contents survive a reset and only
    // the power-up image defines them, which also keeps it mappable to RAM.
    mem_t mem = init_image();

    // One access per enabled edge; a write returns the written word on rdata.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments for all clocked state, so every
        // register samples pre-edge values regardless of statement order.
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the CPU memory-stage interface: accepts one load/store at a
// time, waits WAIT_CYCLES, performs the access (or flags an out-of-range
// address) and holds the response until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int INIT_WORDS  = INIT_WORDS_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [WORD_W-1:0] DEPTH_W   = WORD_W'(DEPTH);
    localparam bit                ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               rdata_zero;     // forces rsp_rdata to 0 after reset or an error

    logic               lat_write;
    logic               lat_err;
    logic [AW-1:0]      lat_addr;
    logic [WORD_W-1:0]  lat_wdata;

    logic               accept;
    logic               req_err;
    logic               acc_now;
    logic               acc_write;
    logic               acc_err;
    logic [AW-1:0]      acc_addr;
    logic [WORD_W-1:0]  acc_wdata;
    logic               ram_en;
    logic [WORD_W-1:0]  ram_rdata;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    // Full-width compare: high address bits never alias onto low words.
    assign req_err   = (req_addr >= DEPTH_W);

    // Pick the access source: live inputs for a zero-wait accept, latched ones after waiting.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        acc_now   = 1'b0;
        acc_write = lat_write;
        acc_err   = lat_err;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_now   = accept && ZERO_WAIT;
            acc_write = req_write;
            acc_err   = req_err;
            acc_addr  = req_addr[AW-1:0];
            acc_wdata = req_wdata;
        end else if (state == WAIT) begin
            acc_now = (count == CNT_W'(1));
        end
    end

    // Reset overrides a due access, so a pending store is dropped.
    assign ram_en = acc_now && !acc_err && !reset;

    dmem_array #(
        .DEPTH      (DEPTH),
        .INIT_WORDS (INIT_WORDS)
    ) u_array (
        .clock (clock),
        .en    (ram_en),
        .we    (acc_write),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Capture the request payload at acceptance; it is only consumed in WAIT.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_addr  <= req_addr[AW-1:0];
            lat_wdata <= req_wdata;
        end
    end

    // Transaction FSM: IDLE -> (WAIT) -> RESP -> IDLE, one request at a time.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
            rdata_zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (ZERO_WAIT) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_error  <= req_err;
                            rdata_zero <= req_err;
                        end else begin
                            count <= WAIT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_error  <= lat_err;
                        rdata_zero <= lat_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The RAM output register only moves on an access, so the data holds through RESP and after.
    assign rsp_rdata = rdata_zero ? '0 : ram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES 1, 3, 0.
module tb_dmem_responder;

    localparam int N = 3;

    logic                clock;
    logic [N-1:0]        reset;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        req_write;
    logic [N-1:0][63:0]  req_addr;
    logic [N-1:0][63:0]  req_wdata;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready;
    logic [N-1:0][63:0]  rsp_rdata;
    logic [N-1:0]        rsp_error;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH       (1024),
            .WAIT_CYCLES (wait_of(g)),
            .INIT_WORDS  (21)
        ) u_dut (
            .clock     (clock),
            .reset     (reset[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_error (rsp_error[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          d;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int d, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] exp_rdata,
                           input logic exp_err);
        vec_t v;
        v.d = d; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for rsp_valid; returns the number of edges waited.
    task automatic wait_rsp(input int d, output int cycles);
        cycles = 0;
        while (!rsp_valid[d] && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    // Full transaction: present, accept, wait for response, handshake.
    task automatic txn(input int d, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int lat);
        int guard;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        guard = 0;
        while (!req_ready[d] && guard < 20) begin
            step();
            guard++;
        end
        step();
        req_valid[d] = 1'b0;
        wait_rsp(d, lat);
        rd = rsp_rdata[d];
        er = rsp_error[d];
        rsp_ready[d] = 1'b1;
        step();
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          accepts;
        int          valids;
        int          stray;

        // NOTE: bench inputs are driven with blocking assignments, #1 after
        // the edge, so the DUT sees stable values at the next rising edge.
        reset     = '1;
        req_valid = '1;      // asserted together with reset: must not be accepted
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;

        // ---------------- reset state ----------------
        repeat (3) step();
        for (int d = 0; d < N; d++) begin
            check($sformatf("d%0d reset req_ready", d), 64'(req_ready[d]), 64'd0);
            check($sformatf("d%0d reset rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
            check($sformatf("d%0d reset rsp_rdata", d), rsp_rdata[d], 64'd0);
            check($sformatf("d%0d reset rsp_error", d), 64'(rsp_error[d]), 64'd0);
        end
        reset = '0;
        #1;
        for (int d = 0; d < N; d++)
            check($sformatf("d%0d ready after reset", d), 64'(req_ready[d]), 64'd1);
        req_valid = '0;
        step();

        // ---------------- table-driven transactions ----------------
        add_vec(0, 1'b0, 64'd5,                  64'd0,           64'd5,           1'b0);
        add_vec(0, 1'b1, 64'd20,                 64'hDEAD_BEEF,   64'hDEAD_BEEF,   1'b0);
        add_vec(0, 1'b0, 64'd20,                 64'd0,           64'hDEAD_BEEF,   1'b0);
        add_vec(0, 1'b0, 64'd19,                 64'd0,           64'd19,          1'b0);
        add_vec(0, 1'b0, 64'd21,                 64'd0,           64'd0,           1'b0);
        add_vec(0, 1'b0, 64'd1024,               64'd0,           64'd0,           1'b1);
        add_vec(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,          64'd0,           1'b1);
        add_vec(0, 1'b0, 64'h0000_0001_0000_0000, 64'd0,          64'd0,           1'b1);
        add_vec(0, 1'b0, 64'h8000_0000_0000_0000, 64'd0,          64'd0,           1'b1);
        add_vec(0, 1'b1, 64'd1024,               64'h1234,        64'd0,           1'b1);
        add_vec(0, 1'b0, 64'd0,                  64'd0,           64'd0,           1'b0);
        add_vec(0, 1'b0, 64'd1023,               64'd0,           64'd0,           1'b0);
        add_vec(0, 1'b1, 64'd1023,               64'hABC,         64'hABC,         1'b0);
        add_vec(0, 1'b0, 64'd1023,               64'd0,           64'hABC,         1'b0);
        add_vec(1, 1'b0, 64'd2,                  64'd0,           64'd2,           1'b0);
        add_vec(2, 1'b0, 64'd10,                 64'd0,           64'd10,          1'b0);
        add_vec(2, 1'b1, 64'd4,                  64'hAA,          64'hAA,          1'b0);
        add_vec(2, 1'b0, 64'd4,                  64'd0,           64'hAA,          1'b0);
        add_vec(2, 1'b0, 64'd1024,               64'd0,           64'd0,           1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d error", i), 64'(er), 64'(vecs[i].exp_err));
            check($sformatf("v%0d latency", i), 64'(lat), 64'(wait_of(vecs[i].d)));
            check($sformatf("v%0d idle after handshake", i),
                  64'({rsp_valid[vecs[i].d], req_ready[vecs[i].d]}), 64'b01);
        end

        // ---------------- backpressure on instance 0 ----------------
        req_write[0] = 1'b0; req_addr[0] = 64'd7; req_valid[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        wait_rsp(0, lat);
        check("bp first valid", 64'(rsp_valid[0]), 64'd1);
        req_write[0] = 1'b1; req_addr[0] = 64'd7; req_wdata[0] = 64'h55;
        for (int c = 0; c < 5; c++) begin
            req_valid[0] = c[0];
            step();
            check($sformatf("bp stall c%0d", c),
                  {rsp_rdata[0][60:0], rsp_valid[0], rsp_error[0], req_ready[0]},
                  {61'd7, 1'b1, 1'b0, 1'b0});
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        step();
        rsp_ready[0] = 1'b0;
        check("bp release", 64'({rsp_valid[0], req_ready[0]}), 64'b01);
        check("bp rdata held", rsp_rdata[0], 64'd7);
        txn(0, 1'b0, 64'd7, 64'd0, rd, er, lat);
        check("bp pulses ignored", rd, 64'd7);

        // ---------------- reset during WAIT on instance 1 (WAIT_CYCLES=3) ----------------
        req_write[1] = 1'b1; req_addr[1] = 64'd3; req_wdata[1] = 64'd7; req_valid[1] = 1'b1;
        step();                 // accept edge
        req_valid[1] = 1'b0;
        step();
        step();                 // the next edge would perform the store
        reset[1] = 1'b1;
        step();
        check("rst_wait valid", 64'(rsp_valid[1]), 64'd0);
        reset[1] = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (rsp_valid[1]) stray++;
        end
        check("rst_wait no response", 64'(stray), 64'd0);
        txn(1, 1'b0, 64'd3, 64'd0, rd, er, lat);
        check("rst_wait store dropped", rd, 64'd3);
        check("rst_wait load latency", 64'(lat), 64'd3);

        // ---------------- reset during RESP on instance 1 ----------------
        req_write[1] = 1'b1; req_addr[1] = 64'd6; req_wdata[1] = 64'd9; req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        wait_rsp(1, lat);
        check("rst_resp reached", 64'(rsp_valid[1]), 64'd1);
        reset[1] = 1'b1;
        step();
        check("rst_resp dropped", 64'({rsp_valid[1], rsp_error[1]}), 64'd0);
        check("rst_resp rdata", rsp_rdata[1], 64'd0);
        reset[1] = 1'b0;
        step();
        txn(1, 1'b0, 64'd6, 64'd0, rd, er, lat);
        check("rst_resp store kept", rd, 64'd9);

        // ---------------- zero-wait back-to-back on instance 2 ----------------
        req_write[2] = 1'b0; req_addr[2] = 64'd10;
        req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
        accepts = 0;
        valids  = 0;
        for (int c = 0; c < 10; c++) begin
            if (req_ready[2]) accepts++;
            if (rsp_valid[2]) begin
                valids++;
                check($sformatf("b2b rdata c%0d", c), rsp_rdata[2], 64'd10);
            end
            step();
        end
        req_valid[2] = 1'b0; rsp_ready[2] = 1'b0;
        check("b2b accepts", 64'(accepts), 64'd5);
        check("b2b responses", 64'(valids), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
